// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - state_t        : FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   - clogb2()       : ceil(log2(n)) with a minimum of 1, for counter widths
//   - DEF_CLK_FREQ   : default system clock frequency in Hz
//   - DEF_DATAWIDTH  : default data bits per frame (tx and rx must agree)
//   - DEF_BAUDRATE   : default line rate in bit/s (tx and rx must agree)
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50000000;
    localparam int DEF_DATAWIDTH = 5;
    localparam int DEF_BAUDRATE  = 9600;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

    // Bits needed to hold the values 0..value-1; never returns less than 1.
    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter shared by the UART transmitter and receiver.
// Ports:
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous, active-low reset
//   en    in   count while high; the counter is held at 0 while low
//   clr   in   synchronous clear to 0 (has priority over en)
//   cnt   out  current count, 0..BIT_CYCLES-1
//   tick  out  high during the cycle in which cnt == BIT_CYCLES-1
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    output logic [clogb2(BIT_CYCLES)-1:0] cnt,
    output logic                          tick
);

    localparam int CW = clogb2(BIT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    assign tick = (cnt == CW'(BIT_CYCLES - 1));

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter.
// Frame: 1 start bit (0), DATAWIDTH data bits LSB first, [even parity bit], 1 stop bit (1).
// Each bit lasts BIT_CYCLES = CLK_FREQ/BAUDRATE clocks (must be >= 2).
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the last data bit and the stop bit.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous, active-low reset
//   in_data  in   word to transmit
//   in_valid in   in_data is valid
//   in_ready out  block can accept a word (high only in IDLE)
//   tx       out  serial line, idles high, registered
//   busy     out  frame in progress
//   tx_done  out  one-cycle pulse after the stop bit completes
// Handshake: a word is transferred on a rising clk edge where in_valid and
// in_ready are both high. in_valid while in_ready is low is ignored; the
// producer must hold in_data until it is accepted. There is no queueing.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int BAUDRATE  = DEF_BAUDRATE,
    parameter int CLK_FREQ  = DEF_CLK_FREQ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
    localparam int CW         = clogb2(BIT_CYCLES);
    localparam int IW         = clogb2(DATAWIDTH + 1);

    state_t               state;
    logic [DATAWIDTH-1:0] shift;
    logic [IW-1:0]        bit_idx;
    logic [CW-1:0]        baud_cnt;
    logic                 baud_tick;
    logic                 handshake;
    logic                 baud_en;
    logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    // Snapshot of the FSM for bound checkers; not consumed by the datapath.
    typedef struct packed {
        state_t        state;
        logic [CW-1:0] baud_cnt;
        logic [IW-1:0] bit_idx;
    } dbg_t;
    dbg_t dbg_unused;
    assign dbg_unused = '{state: state, baud_cnt: baud_cnt, bit_idx: bit_idx};

    assign handshake = in_valid & in_ready;
    assign baud_en   = (state != IDLE);
    // A handshake restarts the bit period so the start bit is a full period.
    assign baud_clr  = handshake | baud_tick;

    uart_baud_cnt #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (baud_en),
        .clr  (baud_clr),
        .cnt  (baud_cnt),
        .tick (baud_tick)
    );

    // The next line level is registered on the same edge that changes state,
    // so tx never passes through combinational logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            in_ready <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        shift    <= in_data;
                        bit_idx  <= '0;
                        state    <= START;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (baud_tick) begin
                        // shift[0] goes on the line now; the register moves on
                        // so the next data bit is always at shift[0].
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == IW'(DATAWIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_q;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        tx_done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, self-checking bench for uart_tx with BIT_CYCLES = 10
// (CLK_FREQ 50 MHz, BAUDRATE 5 Mbit/s) and DATAWIDTH = 5.
// Outputs are sampled 1 ns after the rising edge; inputs are driven there too.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;

    localparam int DW  = 5;
    localparam int BIT = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 8;
    // Line level per bit period, bit b = period b (start, d0..d4, parity, stop).
    localparam logic [7:0] PAT_16 = 8'hEC;  // 5'b10110: 0,0,1,1,0,1,p=1,1
    localparam logic [7:0] PAT_1F = 8'hFE;  // 0,1,1,1,1,1,p=1,1
    localparam logic [7:0] PAT_00 = 8'h80;  // 0,0,0,0,0,0,p=0,1
`else
    localparam int NB = 7;
    localparam logic [7:0] PAT_16 = 8'h6C;  // 5'b10110: 0,0,1,1,0,1,1
    localparam logic [7:0] PAT_1F = 8'h7E;  // 0,1,1,1,1,1,1
    localparam logic [7:0] PAT_00 = 8'h40;  // 0,0,0,0,0,0,1
`endif
    localparam int FRAME = NB * BIT;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int n_tests;
    int n_fail;

    logic          tx_cap   [0:299];
    logic          rdy_cap  [0:299];
    logic          busy_cap [0:299];
    logic          done_cap [0:299];
    logic [DW-1:0] exp_q[$];

    uart_tx #(
        .DATAWIDTH(DW),
        .BAUDRATE (5000000),
        .CLK_FREQ (50000000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        check("rst_tx", tx, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Returns after the handshake edge (+1 ns): that sample is frame cycle 0.
    task automatic send_word(input logic [DW-1:0] d);
        int waited;
        waited = 0;
        while (!in_ready && waited < 200) begin
            next_cycle();
            waited++;
        end
        if (!in_ready) check("send_wait_in_ready", 0, 1);
        in_data  = d;
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
    endtask

    // Records n cycles of outputs. Optionally pulses in_valid with inj_d at
    // cycle inj_c. A pending in_valid is dropped once it has been accepted.
    task automatic capture(input int n, input int inj_c, input logic [DW-1:0] inj_d);
        logic hs;
        for (int c = 0; c < n; c++) begin
            if (c == inj_c) begin
                in_valid = 1'b1;
                in_data  = inj_d;
            end
            tx_cap[c]   = tx;
            rdy_cap[c]  = in_ready;
            busy_cap[c] = busy;
            done_cap[c] = tx_done;
            hs = in_valid & in_ready;
            next_cycle();
            if (hs || c == inj_c) in_valid = 1'b0;
        end
    endtask

    // Checks the line against a hand-computed bit pattern starting at cycle s.
    task automatic check_frame(input string tag, input logic [7:0] pat, input int s);
        int bad;
        for (int b = 0; b < NB; b++)
            check($sformatf("%s_bit%0d", tag, b), tx_cap[s + b*BIT + BIT/2], pat[b]);
        bad = 0;
        for (int c = 0; c < FRAME; c++)
            if (tx_cap[s + c] !== pat[c / BIT]) bad++;
        check($sformatf("%s_shape_errs", tag), bad, 0);
    endtask

    task automatic count_range(input int a, input int b, output int n_rdy0, output int n_busy1,
                               output int n_done, output int n_tx0);
        n_rdy0 = 0; n_busy1 = 0; n_done = 0; n_tx0 = 0;
        for (int c = a; c < b; c++) begin
            if (rdy_cap[c] === 1'b0) n_rdy0++;
            if (busy_cap[c] === 1'b1) n_busy1++;
            if (done_cap[c] === 1'b1) n_done++;
            if (tx_cap[c] !== 1'b1) n_tx0++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad, r0, b1, d1, t0, first_done, second_done;
        logic [DW-1:0] got, exp_w;
        logic [DW-1:0] words [0:2];
        n_tests  = 0;
        n_fail   = 0;
        in_valid = 1'b0;
        in_data  = '0;
        rst_n    = 1'b0;

        // Reset and idle
        do_reset();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
            next_cycle();
        end
        check("idle_bad_cycles", bad, 0);

        // Single frame 5'b10110
        send_word(5'b10110);
        capture(FRAME + 10, -1, '0);
        check_frame("f16", PAT_16, 0);
        count_range(0, FRAME + 10, r0, b1, d1, t0);
        check("f16_in_ready_low_cycles", r0, FRAME);
        check("f16_busy_cycles", b1, FRAME);
        check("f16_done_count", d1, 1);
        check("f16_done_at", done_cap[FRAME], 1);
        check("f16_ready_back", rdy_cap[FRAME], 1);
        count_range(FRAME, FRAME + 10, r0, b1, d1, t0);
        check("f16_idle_tx_after", t0, 0);

        // Back-to-back: in_valid held, data changes right after first accept
        while (!in_ready) next_cycle();
        in_data  = 5'h1F;
        in_valid = 1'b1;
        next_cycle();
        in_data  = 5'h00;
        capture(2*FRAME + 11, -1, '0);
        check("b2b_valid_dropped", in_valid, 0);
        check_frame("b2b_a", PAT_1F, 0);
        check("b2b_stop_tail", tx_cap[FRAME], 1);
        check("b2b_start_follows", tx_cap[FRAME + 1], 0);
        check_frame("b2b_b", PAT_00, FRAME + 1);
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 2*FRAME + 11; c++) begin
            if (done_cap[c] === 1'b1) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        check("b2b_done1_at", first_done, FRAME);
        check("b2b_done2_at", second_done, 2*FRAME + 1);
        count_range(0, 2*FRAME + 11, r0, b1, d1, t0);
        check("b2b_done_count", d1, 2);

        // Word offered while busy is ignored
        send_word(5'b10110);
        capture(FRAME + 30, 25, 5'h0A);
        check_frame("ign", PAT_16, 0);
        count_range(0, FRAME + 30, r0, b1, d1, t0);
        check("ign_done_count", d1, 1);
        count_range(FRAME, FRAME + 30, r0, b1, d1, t0);
        check("ign_no_second_frame", t0, 0);
        check("ign_ready_end", in_ready, 1);

        // Reset at clock 35 of a frame (word 0: line is low there)
        send_word(5'h00);
        capture(35, -1, '0);
        check("mid_rst_pre_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_async", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        capture(FRAME + 30, -1, '0);
        count_range(0, FRAME + 30, r0, b1, d1, t0);
        check("mid_rst_no_done", d1, 0);
        check("mid_rst_ready_low", r0, 0);
        check("mid_rst_line_idle", t0, 0);

        // Loopback decode with expected-word scoreboard
        words[0] = 5'h00;
        words[1] = 5'h15;
        words[2] = 5'h1F;
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(words[w]);
            send_word(words[w]);
            capture(FRAME + 5, -1, '0);
            check($sformatf("lb%0d_start", w), tx_cap[BIT/2], 0);
            for (int i = 0; i < DW; i++) got[i] = tx_cap[(i + 1)*BIT + BIT/2];
            exp_w = exp_q.pop_front();
            check($sformatf("lb%0d_data", w), got, exp_w);
`ifdef UART_TX_PARITY_EN
            check($sformatf("lb%0d_parity", w), tx_cap[(DW + 1)*BIT + BIT/2], ^exp_w);
`endif
            check($sformatf("lb%0d_stop", w), tx_cap[(NB - 1)*BIT + BIT/2], 1);
        end
        check("lb_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
